// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: controller FSM states, framing bit values
// and the frame-width helper used to size the assembled frame.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    HOLD
  } tx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int frame_width(input int data_w, input int parity_en);
    return data_w + 2 + ((parity_en != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: tick is high in the last of every CLKS_PER_BIT enabled
// cycles; clear restarts the period and takes priority over enable.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int               CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a byte for a downstream PISO and paces it with
// load/shift pulses; accepts a new byte only in IDLE, including the tx_done cycle.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int  CLKS_PER_BIT = 868,
  parameter int  DATA_W       = 8,
  parameter int  PARITY_EN    = 0,
  parameter int  PARITY_ODD   = 0,
  localparam int FRAME_W      = frame_width(DATA_W, PARITY_EN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [FRAME_W-1:0] p_data,
  output logic               load,
  output logic               shift,
  output logic               tx_busy,
  output logic               tx_done
);

  localparam int               BIT_W    = $clog2(FRAME_W + 1);
  localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(FRAME_W - 1);

  tx_state_t          state, state_nxt;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic               load_nxt, shift_nxt, done_nxt;
  logic               baud_clear, baud_en, baud_tick;
  logic               handshake;
  logic [FRAME_W-1:0] frame;

  assign tx_ready   = (state == IDLE);
  assign tx_busy    = (state != IDLE);
  assign handshake  = tx_valid && tx_ready;
  assign baud_clear = (state == LOAD);
  // The baud counter keeps running from SEND into HOLD so the stop bit gets a full period.
  assign baud_en    = (state == SEND) || (state == HOLD);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clear),
    .enable(baud_en),
    .tick  (baud_tick)
  );

  always_comb begin
    frame             = '1;
    frame[0]          = START_BIT;
    frame[DATA_W:1]   = tx_data;
    if (PARITY_EN != 0) begin
      frame[FRAME_W-2] = (^tx_data) ^ (PARITY_ODD != 0);
    end
    frame[FRAME_W-1]  = STOP_BIT;
  end

  // Pulses are decided one cycle ahead and registered, so each lands in the
  // cycle the state it belongs to is active.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    load_nxt    = 1'b0;
    shift_nxt   = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (handshake) begin
          state_nxt = LOAD;
          load_nxt  = 1'b1;
        end
      end
      LOAD: begin
        state_nxt   = SEND;
        shift_nxt   = 1'b1;
        bit_cnt_nxt = '0;
      end
      SEND: begin
        if (shift) begin
          bit_cnt_nxt = bit_cnt + 1'b1;
        end
        if (shift && (bit_cnt == LAST_IDX)) begin
          state_nxt = HOLD;
        end else if (baud_tick) begin
          shift_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (baud_tick) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      p_data  <= '1;
      load    <= 1'b0;
      shift   <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      load    <= load_nxt;
      shift   <= shift_nxt;
      tx_done <= done_nxt;
      if (handshake) begin
        p_data <= frame;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: per-cycle comparison against a timeline model derived from
// the handshake cycle, plus a PISO on the outputs to check the serial line.
module tb_uart_tx_ctrl;

  localparam int C        = 4;
  localparam int F        = 10;
  localparam int FP       = 11;
  localparam int DONE_REL = 2 + F * C;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    tx_data = 8'h00;
  logic          tx_valid = 1'b0;
  logic          tx_ready, load, shift, tx_busy, tx_done;
  logic [F-1:0]  p_data;

  logic [7:0]    par_data = 8'h00;
  logic          par_valid = 1'b0;
  logic          pe_ready, pe_load, pe_shift, pe_busy, pe_done;
  logic          po_ready, po_load, po_shift, po_busy, po_done;
  logic [FP-1:0] pe_p_data, po_p_data;

  int            cyc = 0;
  int            n_checks = 0;
  int            n_pass = 0;

  bit            have = 1'b0;
  int            t_hs = 0;
  logic [F-1:0]  m_frame = '1;
  logic [F-1:0]  m_pdata = '1;
  bit            accepted = 1'b0;

  logic [F-1:0]  piso_sr;
  logic          line;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_ctrl #(.CLKS_PER_BIT(C), .DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .p_data(p_data), .load(load), .shift(shift), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(C), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_pe (
    .clk(clk), .rst(rst), .tx_data(par_data), .tx_valid(par_valid), .tx_ready(pe_ready),
    .p_data(pe_p_data), .load(pe_load), .shift(pe_shift), .tx_busy(pe_busy), .tx_done(pe_done)
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(C), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1)) dut_po (
    .clk(clk), .rst(rst), .tx_data(par_data), .tx_valid(par_valid), .tx_ready(po_ready),
    .p_data(po_p_data), .load(po_load), .shift(po_shift), .tx_busy(po_busy), .tx_done(po_done)
  );

  // Downstream PISO: the line idles high and takes the frame LSB first on each shift.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      piso_sr <= '1;
      line    <= 1'b1;
    end else if (load) begin
      piso_sr <= p_data;
    end else if (shift) begin
      line    <= piso_sr[0];
      piso_sr <= {1'b1, piso_sr[F-1:1]};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One cycle: compare outputs against the model, then drive inputs for the coming edge.
  task automatic step(input logic v, input logic [7:0] d);
    int   rel;
    logic e_load, e_shift, e_done, e_busy, e_ready, e_line;
    @(negedge clk);
    e_load = 1'b0; e_shift = 1'b0; e_done = 1'b0;
    e_busy = 1'b0; e_ready = 1'b1; e_line = 1'b1;
    if (have) begin
      rel     = cyc - t_hs;
      e_load  = (rel == 1);
      e_shift = (rel >= 2) && ((rel - 2) % C == 0) && ((rel - 2) / C < F);
      e_done  = (rel == DONE_REL);
      e_busy  = (rel >= 1) && (rel < DONE_REL);
      e_ready = (rel >= DONE_REL);
      if ((rel >= 3) && ((rel - 3) / C < F)) e_line = m_frame[(rel - 3) / C];
    end
    check("load", load, e_load);
    check("shift", shift, e_shift);
    check("tx_done", tx_done, e_done);
    check("tx_busy", tx_busy, e_busy);
    check("p_data", p_data, m_pdata);
    check("serial", line, e_line);
    if (!rst) check("tx_ready", tx_ready, e_ready);
    tx_valid = v;
    tx_data  = d;
    accepted = 1'b0;
    if (!rst && e_ready && v) begin
      have     = 1'b1;
      t_hs     = cyc;
      m_frame  = {1'b1, d, 1'b0};
      m_pdata  = m_frame;
      accepted = 1'b1;
    end
  endtask

  task automatic send_held(input logic [7:0] d);
    int i;
    i = 0;
    accepted = 1'b0;
    while (!accepted && i < 100) begin
      step(1'b1, d);
      i++;
    end
    check("hs_timeout", accepted, 1);
  endtask

  task automatic run_parity();
    int t0, ns_e, ns_o, lat_e, lat_o;
    @(negedge clk);
    check("par_ready", {pe_ready, po_ready}, 2'b11);
    par_data  = 8'hA5;
    par_valid = 1'b1;
    t0 = cyc;
    @(negedge clk);
    par_valid = 1'b0;
    check("par_load", {pe_load, po_load}, 2'b11);
    check("par_busy", {pe_busy, po_busy}, 2'b11);
    check("par_even_frame", pe_p_data, 11'h54A);
    check("par_odd_frame", po_p_data, 11'h74A);
    ns_e = 0; ns_o = 0; lat_e = -1; lat_o = -1;
    for (int i = 0; i < 80 && (lat_e < 0 || lat_o < 0); i++) begin
      @(negedge clk);
      if (pe_shift) ns_e++;
      if (po_shift) ns_o++;
      if (pe_done && lat_e < 0) lat_e = cyc - t0;
      if (po_done && lat_o < 0) lat_o = cyc - t0;
    end
    check("par_even_shifts", ns_e, FP);
    check("par_odd_shifts", ns_o, FP);
    check("par_even_done_lat", lat_e, 2 + FP * C);
    check("par_odd_done_lat", lat_o, 2 + FP * C);
  endtask

  initial begin : main
    int       t_a, t_b;
    bit       hold_v;
    logic     v;
    logic [7:0] d, hold_d;

    repeat (3) step(1'b0, 8'h00);
    rst = 1'b0;
    repeat (2) step(1'b0, 8'h00);

    // First frame after reset, then a busy-time pulse that must be ignored.
    send_held(8'hA5);
    t_a = t_hs;
    step(1'b0, 8'h00);
    check("a5_frame", p_data, 10'h34A);
    repeat (8) step(1'b0, 8'h00);
    step(1'b1, 8'h3C);
    check("busy_pulse_ignored", accepted, 0);
    repeat (5) step(1'b0, 8'h00);
    send_held(8'h3C);
    check("held_hs_at_done", t_hs - t_a, DONE_REL);

    // Back-to-back frames with valid held high.
    t_b = t_hs;
    send_held(8'h00);
    check("b2b_gap_1", t_hs - t_b, DONE_REL);
    t_b = t_hs;
    step(1'b1, 8'hFF);
    check("b2b_frame_00", p_data, 10'h200);
    send_held(8'hFF);
    check("b2b_gap_2", t_hs - t_b, DONE_REL);
    step(1'b0, 8'h00);
    check("b2b_frame_ff", p_data, 10'h3FE);

    // Reset in the middle of a frame.
    repeat (DONE_REL) step(1'b0, 8'h00);
    send_held(8'h77);
    repeat (20) step(1'b0, 8'h00);
    #2 rst = 1'b1;
    #1;
    check("rst_p_data", p_data, 10'h3FF);
    check("rst_pulses", {load, shift, tx_done, tx_busy}, 4'b0000);
    have    = 1'b0;
    m_pdata = '1;
    repeat (4) step(1'b0, 8'h00);
    rst = 1'b0;
    repeat (2) step(1'b0, 8'h00);
    send_held(8'h5A);
    step(1'b0, 8'h00);
    check("rst_resend_frame", p_data, 10'h2B4);
    repeat (DONE_REL + 2) step(1'b0, 8'h00);

    // Random traffic: sporadic valid, sometimes held until accepted, sometimes dropped.
    hold_v = 1'b0;
    hold_d = 8'h00;
    repeat (1500) begin
      if (hold_v) begin
        step(1'b1, hold_d);
      end else begin
        v = ($urandom_range(0, 3) == 0);
        d = 8'($urandom);
        step(v, d);
        if (v && !accepted && ($urandom_range(0, 1) == 1)) begin
          hold_v = 1'b1;
          hold_d = d;
        end
      end
      if (accepted) hold_v = 1'b0;
    end
    repeat (DONE_REL + 5) step(1'b0, 8'h00);

    run_parity();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
